// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// opcode values, ALU select/op encodings and the bundled control word.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_RT  = 7'b0110011;
  localparam logic [6:0] OP_IT  = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       memtoreg;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] aluop;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_RT) || (op == OP_IT) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational control decode: registered state plus latched opcode give the
// datapath controls; zero and mem_ready qualify branch and memory completion.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.alusrc_b = SRCB_FOUR;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_RT: begin
            ctrl.alusrc_a = 1'b1;
            ctrl.alusrc_b = SRCB_REG;
            ctrl.aluop    = ALUOP_FUNC;
          end
          OP_IT: begin
            ctrl.alusrc_a = 1'b1;
            ctrl.alusrc_b = SRCB_IMM;
            ctrl.aluop    = ALUOP_FUNC;
          end
          OP_LW, OP_SW: begin
            ctrl.alusrc_a = 1'b1;
            ctrl.alusrc_b = SRCB_IMM;
            ctrl.aluop    = ALUOP_ADD;
          end
          OP_BEQ: begin
            ctrl.alusrc_a   = 1'b1;
            ctrl.alusrc_b   = SRCB_REG;
            ctrl.aluop      = ALUOP_BR;
            ctrl.pc_write   = zero;
            ctrl.pc_src     = zero;
            ctrl.instr_done = 1'b1;
          end
          // Unknown opcodes retire as a NOP with no write enables.
          default: ctrl.instr_done = 1'b1;
        endcase
      end
      S_MEM: begin
        ctrl.mem_req    = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.mem_we     = (opcode == OP_SW);
        ctrl.instr_done = mem_ready && (opcode == OP_SW);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.memtoreg   = (opcode == OP_LW);
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with memory-wait timeout.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes into HALT.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        memtoreg,
  output logic        alusrc_a,
  output logic [1:0]  alusrc_b,
  output logic [1:0]  aluop,
  output logic        instr_done,
  output logic        timeout,
  output logic [31:0] instret
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [6:0]        op_q;
  logic              active;
  logic              timeout_set;
  ctrl_t             dec, ctrl;

  mc_out_decode u_decode (
    .state     (state_q),
    .opcode    (op_q),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  // The cycle right after a reset edge is idle so any abandoned access drops.
  always_comb ctrl = active ? dec : '0;

  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    unique case (state_q)
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          if (state_q == S_FETCH)   state_d = S_DECODE;
          else if (op_q == OP_LW)   state_d = S_WB;
          else                      state_d = S_FETCH;
        end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
          state_d     = S_HALT;
          timeout_set = 1'b1;
        end
      end
      S_DECODE: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        if (!is_known_op(opcode)) state_d = S_HALT;
        else                      state_d = S_EXEC;
`else
        state_d = S_EXEC;
`endif
      end
      S_EXEC: begin
        case (op_q)
          OP_RT, OP_IT: state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_FETCH;
        endcase
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase

    if (state_d != state_q)  wait_d = '0;
    else if (!mem_ready)     wait_d = wait_q + WAIT_W'(1);
    else                     wait_d = wait_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      op_q    <= '0;
      active  <= 1'b0;
      timeout <= 1'b0;
      instret <= '0;
    end else begin
      active <= 1'b1;
      if (active) begin
        state_q <= state_d;
        wait_q  <= wait_d;
        if (state_q == S_DECODE) op_q <= opcode;
        if (ctrl.instr_done)     instret <= instret + 32'd1;
        if (timeout_set)         timeout <= 1'b1;
      end
    end
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      illegal <= 1'b0;
    else if (active && state_q == S_DECODE && !is_known_op(opcode))
      illegal <= 1'b1;
  end
`endif

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign reg_write  = ctrl.reg_write;
  assign memtoreg   = ctrl.memtoreg;
  assign alusrc_a   = ctrl.alusrc_a;
  assign alusrc_b   = ctrl.alusrc_b;
  assign aluop      = ctrl.aluop;
  assign instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each
// instruction class, memory waits, timeout/HALT, reset and unknown opcodes.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = OP_RT;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic        reg_write, memtoreg, alusrc_a, instr_done, timeout;
  logic [1:0]  alusrc_b, aluop;
  logic [31:0] instret;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_instret = '0;

  multicycle_ctrl #(.WAIT_MAX(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .memtoreg   (memtoreg),
    .alusrc_a   (alusrc_a),
    .alusrc_b   (alusrc_b),
    .aluop      (aluop),
    .instr_done (instr_done),
    .timeout    (timeout),
    .instret    (instret)
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal    (illegal)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, memtoreg,
  //  alusrc_a, alusrc_b, aluop, instr_done}
  wire [13:0] obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                     reg_write, memtoreg, alusrc_a, alusrc_b, aluop, instr_done};

  localparam logic [13:0] E_ZERO    = 14'b0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [13:0] E_FW      = 14'b1_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [13:0] E_FR      = 14'b1_0_0_1_1_0_0_0_0_01_00_0;
  localparam logic [13:0] E_EX_RT   = 14'b0_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [13:0] E_EX_IT   = 14'b0_0_0_0_0_0_0_0_1_10_10_0;
  localparam logic [13:0] E_EX_LS   = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [13:0] E_EX_BT   = 14'b0_0_0_0_1_1_0_0_1_00_01_1;
  localparam logic [13:0] E_EX_BN   = 14'b0_0_0_0_0_0_0_0_1_00_01_1;
  localparam logic [13:0] E_EX_NOP  = 14'b0_0_0_0_0_0_0_0_0_00_00_1;
  localparam logic [13:0] E_MEM_LW  = 14'b1_0_1_0_0_0_0_0_0_00_00_0;
  localparam logic [13:0] E_MEM_SW  = 14'b1_1_1_0_0_0_0_0_0_00_00_0;
  localparam logic [13:0] E_MEM_SWD = 14'b1_1_1_0_0_0_0_0_0_00_00_1;
  localparam logic [13:0] E_WB      = 14'b0_0_0_0_0_0_1_0_0_00_00_1;
  localparam logic [13:0] E_WB_LW   = 14'b0_0_0_0_0_0_1_1_0_00_00_1;
  localparam logic [6:0]  OP_BAD    = 7'b1111111;

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic apply(input logic [6:0] op, input logic rdy, input logic z);
    @(negedge clk);
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== E_ZERO) begin
      failures++;
      $display("FAIL %s_outputs_in_reset got=%b exp=%b", tag, obs, E_ZERO);
    end
    checks++;
    if (instret !== 32'd0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL %s_counters_in_reset instret=%0d timeout=%b exp 0/0", tag, instret, timeout);
    end
    rst_n = 1'b1;
    exp_instret = '0;
  endtask

  task automatic test_reset();
    do_reset("reset");
    apply(OP_RT, 1'b0, 1'b0);
    checks++;
    if (obs !== E_FW) begin
      failures++;
      $display("FAIL reset_first_fetch got=%b exp=%b", obs, E_FW);
    end
  endtask

  task automatic test_rt();
    logic [22:0] rows [4];
    rows = '{{OP_RT, 2'b10, E_FR}, {OP_RT, 2'b00, E_ZERO},
             {OP_RT, 2'b00, E_EX_RT}, {OP_RT, 2'b00, E_WB}};
    foreach (rows[i]) begin
      apply(rows[i][22:16], rows[i][15], rows[i][14]);
      checks++;
      if (obs !== rows[i][13:0]) begin
        failures++;
        $display("FAIL rt_cycle%0d got=%b exp=%b", i + 1, obs, rows[i][13:0]);
      end
    end
    exp_instret++;
    apply(OP_RT, 1'b0, 1'b0);
    checks++;
    if (instret !== exp_instret || obs !== E_FW) begin
      failures++;
      $display("FAIL rt_retire instret=%0d exp=%0d obs=%b exp=%b", instret, exp_instret, obs, E_FW);
    end
  endtask

  task automatic test_lw();
    logic [22:0] rows [7];
    rows = '{{OP_LW, 2'b10, E_FR}, {OP_LW, 2'b00, E_ZERO}, {OP_LW, 2'b00, E_EX_LS},
             {OP_LW, 2'b00, E_MEM_LW}, {OP_LW, 2'b00, E_MEM_LW},
             {OP_LW, 2'b10, E_MEM_LW}, {OP_LW, 2'b00, E_WB_LW}};
    foreach (rows[i]) begin
      apply(rows[i][22:16], rows[i][15], rows[i][14]);
      checks++;
      if (obs !== rows[i][13:0]) begin
        failures++;
        $display("FAIL lw_cycle%0d got=%b exp=%b", i + 1, obs, rows[i][13:0]);
      end
    end
    exp_instret++;
  endtask

  task automatic test_beq();
    logic [22:0] rows [6];
    rows = '{{OP_BEQ, 2'b10, E_FR}, {OP_BEQ, 2'b00, E_ZERO}, {OP_BEQ, 2'b01, E_EX_BT},
             {OP_BEQ, 2'b10, E_FR}, {OP_BEQ, 2'b00, E_ZERO}, {OP_BEQ, 2'b00, E_EX_BN}};
    foreach (rows[i]) begin
      apply(rows[i][22:16], rows[i][15], rows[i][14]);
      checks++;
      if (obs !== rows[i][13:0]) begin
        failures++;
        $display("FAIL beq_step%0d got=%b exp=%b", i + 1, obs, rows[i][13:0]);
      end
    end
    exp_instret += 2;
  endtask

  task automatic test_sw();
    logic [22:0] rows [6];
    rows = '{{OP_SW, 2'b00, E_FW}, {OP_SW, 2'b10, E_FR}, {OP_SW, 2'b00, E_ZERO},
             {OP_SW, 2'b00, E_EX_LS}, {OP_SW, 2'b00, E_MEM_SW}, {OP_SW, 2'b10, E_MEM_SWD}};
    foreach (rows[i]) begin
      apply(rows[i][22:16], rows[i][15], rows[i][14]);
      checks++;
      if (obs !== rows[i][13:0]) begin
        failures++;
        $display("FAIL sw_cycle%0d got=%b exp=%b", i + 1, obs, rows[i][13:0]);
      end
    end
    exp_instret++;
    apply(OP_SW, 1'b0, 1'b0);
    checks++;
    if (instret !== exp_instret || obs !== E_FW) begin
      failures++;
      $display("FAIL sw_retire instret=%0d exp=%0d obs=%b exp=%b", instret, exp_instret, obs, E_FW);
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] rows [8];
    rows = '{{OP_IT, 2'b10, E_FR}, {OP_IT, 2'b00, E_ZERO}, {OP_IT, 2'b00, E_EX_IT},
             {OP_IT, 2'b00, E_WB},
             {OP_RT, 2'b10, E_FR}, {OP_RT, 2'b00, E_ZERO}, {OP_RT, 2'b00, E_EX_RT},
             {OP_RT, 2'b00, E_WB}};
    foreach (rows[i]) begin
      apply(rows[i][22:16], rows[i][15], rows[i][14]);
      checks++;
      if (obs !== rows[i][13:0]) begin
        failures++;
        $display("FAIL b2b_cycle%0d got=%b exp=%b", i + 1, obs, rows[i][13:0]);
      end
    end
    exp_instret += 2;
    apply(OP_RT, 1'b0, 1'b0);
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL b2b_instret got=%0d exp=%0d", instret, exp_instret);
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] rows [4];
    rows = '{{OP_LW, 2'b10, E_FR}, {OP_LW, 2'b00, E_ZERO}, {OP_LW, 2'b00, E_EX_LS},
             {OP_LW, 2'b00, E_MEM_LW}};
    foreach (rows[i]) begin
      apply(rows[i][22:16], rows[i][15], rows[i][14]);
      checks++;
      if (obs !== rows[i][13:0]) begin
        failures++;
        $display("FAIL midrst_cycle%0d got=%b exp=%b", i + 1, obs, rows[i][13:0]);
      end
    end
    do_reset("midrst");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 15; i++) begin
      apply(OP_RT, 1'b0, 1'b0);
      checks++;
      if (obs !== E_FW || timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait%0d got=%b timeout=%b exp=%b/0", i + 1, obs, timeout, E_FW);
      end
    end
    for (int i = 0; i < 3; i++) begin
      apply(OP_RT, 1'b1, 1'b0);
      checks++;
      if (obs !== E_ZERO || timeout !== 1'b1 || instret !== exp_instret) begin
        failures++;
        $display("FAIL timeout_halt%0d got=%b timeout=%b instret=%0d exp=%b/1/%0d",
                 i, obs, timeout, instret, E_ZERO, exp_instret);
      end
    end
    do_reset("timeout");
    apply(OP_RT, 1'b0, 1'b0);
    checks++;
    if (obs !== E_FW || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_recover got=%b timeout=%b exp=%b/0", obs, timeout, E_FW);
    end
  endtask

  task automatic test_illegal();
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic [22:0] rows [5];
    rows = '{{OP_BAD, 2'b10, E_FR}, {OP_BAD, 2'b00, E_ZERO}, {OP_BAD, 2'b00, E_ZERO},
             {OP_BAD, 2'b10, E_ZERO}, {OP_BAD, 2'b10, E_ZERO}};
`else
    logic [22:0] rows [5];
    rows = '{{OP_BAD, 2'b10, E_FR}, {OP_BAD, 2'b00, E_ZERO}, {OP_BAD, 2'b00, E_EX_NOP},
             {OP_BAD, 2'b00, E_FW}, {OP_BAD, 2'b00, E_FW}};
`endif
    foreach (rows[i]) begin
      apply(rows[i][22:16], rows[i][15], rows[i][14]);
      checks++;
      if (obs !== rows[i][13:0]) begin
        failures++;
        $display("FAIL illegal_cycle%0d got=%b exp=%b", i + 1, obs, rows[i][13:0]);
      end
    end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    checks++;
    if (illegal !== 1'b1 || instret !== exp_instret) begin
      failures++;
      $display("FAIL illegal_trap illegal=%b instret=%0d exp 1/%0d", illegal, instret, exp_instret);
    end
`else
    exp_instret++;
    checks++;
    if (instret !== exp_instret) begin
      failures++;
      $display("FAIL illegal_nop_instret got=%0d exp=%0d", instret, exp_instret);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rt();
    test_lw();
    test_beq();
    test_sw();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
